irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter VECT_BASE, default 32'h0000_0100, trap vector base address.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port irq_req_i  input  1  interrupt request from the adapter; level, held until acked.
REQ-005 SHALL have port irq_code_bi  input  8  interrupt code accompanying irq_req_i.
REQ-006 SHALL have port irq_ack_o  output  1  one-cycle acknowledge to the adapter.
REQ-007 SHALL have port irq_en_i  input  1  global interrupt enable from the core CSR.
REQ-008 SHALL have port core_ready_i  input  1  core at instruction boundary; trap may be taken.
REQ-009 SHALL have port core_pc_bi  input  32  PC of the next instruction to execute.
REQ-010 SHALL have port irq_ret_i  input  1  handler-return (mret) pulse from the core.
REQ-011 SHALL have port irq_trap_o  output  1  one-cycle trap pulse to the core.
REQ-012 SHALL have port irq_vec_bo  output  32  trap target address.
REQ-013 SHALL have port irq_mepc_bo  output  32  saved return PC.
REQ-014 SHALL have port irq_mcause_bo  output  8  saved interrupt code.
REQ-015 SHALL have port irq_busy_o  output  1  handler in progress.
REQ-016 SHALL have port spur_cnt_bo  output  8  count of spurious (code 0) requests.

Function
REQ-017 SHALL implement FSM states IDLE, ACK, HANDLER.
REQ-018 SHALL, in IDLE, accept when irq_req_i && irq_en_i && core_ready_i at a rising edge; otherwise remain IDLE.
REQ-019 SHALL, on accept with irq_code_bi != 0, latch irq_mcause_bo <= irq_code_bi, irq_mepc_bo <= core_pc_bi, irq_vec_bo <= VECT_BASE + (irq_code_bi << 2) (32-bit, modulo 2^32), and enter ACK.
REQ-020 SHALL, on accept with irq_code_bi == 0 (spurious), leave mcause/mepc/vec unchanged, increment spur_cnt_bo saturating at 8'hFF, and enter ACK.
REQ-021 SHALL assert irq_ack_o for exactly the one cycle spent in ACK (cycle after accept edge); irq_ack_o is 0 in all other states.
REQ-022 SHALL assert irq_trap_o in ACK only for non-spurious accepts, coincident with irq_ack_o.
REQ-023 SHALL leave ACK after one cycle: to HANDLER if non-spurious, to IDLE if spurious.
REQ-024 SHALL ignore irq_req_i in ACK; the request still high in the ACK cycle is not re-accepted.
REQ-025 SHALL hold irq_busy_o = 1 in ACK (non-spurious) and HANDLER, 0 otherwise.
REQ-026 SHALL ignore irq_req_i in HANDLER (no nesting); request remains pending at the adapter.
REQ-027 SHALL return HANDLER -> IDLE on irq_ret_i; irq_ret_i in IDLE or ACK is ignored.
REQ-028 SHALL, on simultaneous irq_ret_i and irq_req_i in HANDLER, go to IDLE only; the request is accepted no earlier than the following edge.
REQ-029 SHALL keep irq_mepc_bo, irq_mcause_bo, irq_vec_bo stable until the next non-spurious accept.
REQ-030 SHALL make irq_en_i deassertion in ACK or HANDLER have no effect on the in-progress sequence.

Reset
REQ-031 SHALL, with rst_i high at an edge, set state IDLE and all outputs to 0 (irq_ack_o, irq_trap_o, irq_busy_o, irq_vec_bo, irq_mepc_bo, irq_mcause_bo, spur_cnt_bo).
REQ-032 SHALL, on reset in ACK or HANDLER, abort the sequence without generating a further ack or trap.

Verification
REQ-033 SHALL cover: req=1, code=8'h03, en=1, ready=1, pc=32'h200 at edge k -> cycle k+1 ack=1, trap=1, vec=32'h10C, mepc=32'h200, mcause=3; cycle k+2 busy=1, ack=0.
REQ-034 SHALL cover: req=1 with en=0 or ready=0 for 10 cycles -> no ack, no trap; raising ready -> ack one cycle later.
REQ-035 SHALL cover: code=0 accept -> ack=1, trap=0, spur_cnt 0->1, state IDLE after; 300 spurious accepts -> spur_cnt=8'hFF.
REQ-036 SHALL cover: second req during HANDLER -> no ack; irq_ret_i -> IDLE, then ack one edge later; simultaneous ret+req -> ack two cycles after ret edge.
REQ-037 SHALL cover: rst_i asserted in HANDLER -> next cycle all outputs 0, busy=0; no ack until a fresh accept.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: single-level interrupt controller sequencing accept, ack/trap and handler return
module irq_ctrl #(
   parameter logic [31:0] VECT_BASE = 32'h0000_0100
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        irq_req_i,
   input  logic [7:0]  irq_code_bi,
   output logic        irq_ack_o,
   input  logic        irq_en_i,
   input  logic        core_ready_i,
   input  logic [31:0] core_pc_bi,
   input  logic        irq_ret_i,
   output logic        irq_trap_o,
   output logic [31:0] irq_vec_bo,
   output logic [31:0] irq_mepc_bo,
   output logic [7:0]  irq_mcause_bo,
   output logic        irq_busy_o,
   output logic [7:0]  spur_cnt_bo
);
   typedef enum logic [1:0] {IDLE, ACK, HANDLER} state_t;
   state_t state;
   logic accept;
   logic spur;
   assign accept = irq_req_i && irq_en_i && core_ready_i;
   assign spur = irq_code_bi == 8'h00;
   // sequencer: all outputs registered; trap doubles as the non-spurious flag while in ACK
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         irq_ack_o <= 1'b0;
         irq_trap_o <= 1'b0;
         irq_busy_o <= 1'b0;
         irq_vec_bo <= 32'h0;
         irq_mepc_bo <= 32'h0;
         irq_mcause_bo <= 8'h0;
         spur_cnt_bo <= 8'h0;
      end else begin
         irq_ack_o <= 1'b0;
         irq_trap_o <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               state <= ACK;
               irq_ack_o <= 1'b1;
               irq_trap_o <= !spur;
               irq_busy_o <= !spur;
               if (spur) begin
                  spur_cnt_bo <= spur_cnt_bo == 8'hFF ? spur_cnt_bo : spur_cnt_bo + 8'h01;
               end else begin
                  irq_mcause_bo <= irq_code_bi;
                  irq_mepc_bo <= core_pc_bi;
                  irq_vec_bo <= VECT_BASE + {22'h0, irq_code_bi, 2'b00};
               end
            end
            ACK: state <= irq_trap_o ? HANDLER : IDLE;
            HANDLER: if (irq_ret_i) begin
               state <= IDLE;
               irq_busy_o <= 1'b0;
            end
            default: begin
               state <= IDLE;
               irq_busy_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl
module tb_irq_ctrl;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        irq_req_i = 1'b0;
   logic [7:0]  irq_code_bi = 8'h0;
   logic        irq_ack_o;
   logic        irq_en_i = 1'b0;
   logic        core_ready_i = 1'b0;
   logic [31:0] core_pc_bi = 32'h0;
   logic        irq_ret_i = 1'b0;
   logic        irq_trap_o;
   logic [31:0] irq_vec_bo;
   logic [31:0] irq_mepc_bo;
   logic [7:0]  irq_mcause_bo;
   logic        irq_busy_o;
   logic [7:0]  spur_cnt_bo;
   int n_chk = 0;
   int n_fail = 0;

   irq_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .irq_req_i(irq_req_i), .irq_code_bi(irq_code_bi),
      .irq_ack_o(irq_ack_o), .irq_en_i(irq_en_i), .core_ready_i(core_ready_i),
      .core_pc_bi(core_pc_bi), .irq_ret_i(irq_ret_i), .irq_trap_o(irq_trap_o),
      .irq_vec_bo(irq_vec_bo), .irq_mepc_bo(irq_mepc_bo), .irq_mcause_bo(irq_mcause_bo),
      .irq_busy_o(irq_busy_o), .spur_cnt_bo(spur_cnt_bo)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " ack"}, {31'h0, irq_ack_o}, 32'h0);
      chk({tag, " trap"}, {31'h0, irq_trap_o}, 32'h0);
      chk({tag, " busy"}, {31'h0, irq_busy_o}, 32'h0);
      chk({tag, " vec"}, irq_vec_bo, 32'h0);
      chk({tag, " mepc"}, irq_mepc_bo, 32'h0);
      chk({tag, " mcause"}, {24'h0, irq_mcause_bo}, 32'h0);
      chk({tag, " spur"}, {24'h0, spur_cnt_bo}, 32'h0);
   endtask

   initial begin
      cyc(2);
      chk_all_zero("reset");
      rst_i = 1'b0;
      // basic accept
      irq_req_i = 1'b1; irq_code_bi = 8'h03; irq_en_i = 1'b1; core_ready_i = 1'b1; core_pc_bi = 32'h200;
      cyc(1);
      chk("b ack", {31'h0, irq_ack_o}, 32'h1);
      chk("b trap", {31'h0, irq_trap_o}, 32'h1);
      chk("b vec", irq_vec_bo, 32'h10C);
      chk("b mepc", irq_mepc_bo, 32'h200);
      chk("b mcause", {24'h0, irq_mcause_bo}, 32'h3);
      chk("b busy ack", {31'h0, irq_busy_o}, 32'h1);
      cyc(1);
      chk("b ack2", {31'h0, irq_ack_o}, 32'h0);
      chk("b trap2", {31'h0, irq_trap_o}, 32'h0);
      chk("b busy2", {31'h0, irq_busy_o}, 32'h1);
      cyc(2);
      chk("b hold ack", {31'h0, irq_ack_o}, 32'h0);
      irq_req_i = 1'b0; irq_ret_i = 1'b1;
      cyc(1);
      irq_ret_i = 1'b0;
      chk("b ret busy", {31'h0, irq_busy_o}, 32'h0);
      // gated by enable then ready
      irq_req_i = 1'b1; irq_code_bi = 8'h05; irq_en_i = 1'b0; core_pc_bi = 32'h400;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk("en0 ack", {31'h0, irq_ack_o}, 32'h0);
         chk("en0 trap", {31'h0, irq_trap_o}, 32'h0);
      end
      irq_en_i = 1'b1; core_ready_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk("rdy0 ack", {31'h0, irq_ack_o}, 32'h0);
         chk("rdy0 trap", {31'h0, irq_trap_o}, 32'h0);
      end
      core_ready_i = 1'b1;
      cyc(1);
      chk("rdy ack", {31'h0, irq_ack_o}, 32'h1);
      chk("rdy vec", irq_vec_bo, 32'h114);
      chk("rdy mepc", irq_mepc_bo, 32'h400);
      irq_req_i = 1'b0;
      cyc(1);
      irq_ret_i = 1'b1;
      cyc(1);
      irq_ret_i = 1'b0;
      // spurious accept
      irq_req_i = 1'b1; irq_code_bi = 8'h00; core_pc_bi = 32'h800;
      cyc(1);
      chk("sp ack", {31'h0, irq_ack_o}, 32'h1);
      chk("sp trap", {31'h0, irq_trap_o}, 32'h0);
      chk("sp busy", {31'h0, irq_busy_o}, 32'h0);
      chk("sp cnt", {24'h0, spur_cnt_bo}, 32'h1);
      chk("sp mcause", {24'h0, irq_mcause_bo}, 32'h5);
      chk("sp mepc", irq_mepc_bo, 32'h400);
      irq_req_i = 1'b0;
      cyc(1);
      chk("sp idle ack", {31'h0, irq_ack_o}, 32'h0);
      chk("sp idle busy", {31'h0, irq_busy_o}, 32'h0);
      irq_ret_i = 1'b1;
      cyc(1);
      irq_ret_i = 1'b0;
      irq_req_i = 1'b1;
      cyc(1);
      chk("sp back idle ack", {31'h0, irq_ack_o}, 32'h1);
      chk("sp cnt2", {24'h0, spur_cnt_bo}, 32'h2);
      cyc(700);
      chk("sp sat", {24'h0, spur_cnt_bo}, 32'hFF);
      chk("sp sat vec", irq_vec_bo, 32'h114);
      irq_req_i = 1'b0;
      cyc(2);
      // no nesting, ret+req collision, enable drop mid-handler
      irq_req_i = 1'b1; irq_code_bi = 8'hFF; core_pc_bi = 32'h300;
      cyc(1);
      chk("n ack", {31'h0, irq_ack_o}, 32'h1);
      chk("n vec", irq_vec_bo, 32'h4FC);
      irq_code_bi = 8'h02; irq_en_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk("n nest ack", {31'h0, irq_ack_o}, 32'h0);
         chk("n busy", {31'h0, irq_busy_o}, 32'h1);
      end
      irq_en_i = 1'b1; irq_ret_i = 1'b1;
      cyc(1);
      irq_ret_i = 1'b0;
      chk("n ret ack", {31'h0, irq_ack_o}, 32'h0);
      chk("n ret busy", {31'h0, irq_busy_o}, 32'h0);
      cyc(1);
      chk("n re ack", {31'h0, irq_ack_o}, 32'h1);
      chk("n re mcause", {24'h0, irq_mcause_bo}, 32'h2);
      chk("n re vec", irq_vec_bo, 32'h108);
      irq_req_i = 1'b0;
      cyc(2);
      // reset while in handler
      rst_i = 1'b1;
      cyc(1);
      rst_i = 1'b0;
      chk_all_zero("rst hdl");
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("rst no ack", {31'h0, irq_ack_o}, 32'h0);
         chk("rst no trap", {31'h0, irq_trap_o}, 32'h0);
      end
      irq_req_i = 1'b1; irq_code_bi = 8'h40; core_pc_bi = 32'h1234;
      cyc(1);
      chk("fresh ack", {31'h0, irq_ack_o}, 32'h1);
      chk("fresh vec", irq_vec_bo, 32'h200);
      chk("fresh mepc", irq_mepc_bo, 32'h1234);
      irq_req_i = 1'b0;
      cyc(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
